// File: rtl/ro_freq_counter.sv
// ro_freq_counter: measures a ring oscillator by counting rising edges of ro_in
// over a fixed window of clk cycles.
//
// A start pulse in idle latches stage_sel and enables the oscillator. The
// oscillator then runs SETTLE_CYCLES cycles uncounted, followed by a
// GATE_CYCLES-cycle counting window. done then pulses for one cycle, and
// count/overflow hold the window result until the next done.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   ro_in      ring-oscillator output, asynchronous to clk
//   start      single-cycle measurement request, honoured only when idle
//   stage_sel  oscillator length select (00=1 .. 11=4 stages), latched on start
//   ro_en      registered oscillator enable code {enable, stage_sel}
//   busy       high from the cycle after an accepted start through done
//   done       one-cycle pulse; count/overflow are valid with it
//   count      rising edges seen in the last window, saturating
//   overflow   last window's count saturated
module ro_freq_counter #(
   parameter int unsigned GATE_CYCLES   = 1024,
   parameter int unsigned SETTLE_CYCLES = 8,
   parameter int unsigned CNT_W         = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ro_in,
   input  logic             start,
   input  logic [1:0]       stage_sel,
   output logic [2:0]       ro_en,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] count,
   output logic             overflow
);

   localparam int unsigned TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
   localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

   localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
   localparam logic [TMR_W-1:0] GATE_LAST   = TMR_W'(GATE_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StSettle, StGate, StDone} state_e;

   state_e           state_q, state_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic [1:0]       sel_q, sel_d;
   logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
   logic             edge_ovf_q, edge_ovf_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             overflow_q, overflow_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;
   logic [2:0]       ro_en_q, ro_en_d;

   // Two-flop synchronizer plus one delay flop for edge detection.
   logic ro_meta_q, ro_meta_d;
   logic ro_sync_q, ro_sync_d;
   logic ro_dly_q, ro_dly_d;
   logic ro_rise;

   always_comb begin
      ro_meta_d = ro_in;
      ro_sync_d = ro_meta_q;
      ro_dly_d  = ro_sync_q;
   end

   assign ro_rise = ro_sync_q & ~ro_dly_q;

   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q + 1'b1;
      sel_d      = sel_q;
      edge_cnt_d = edge_cnt_q;
      edge_ovf_d = edge_ovf_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      done_d     = 1'b0;

      unique case (state_q)
         StIdle: begin
            timer_d = timer_q;
            if (start) begin
               sel_d      = stage_sel;
               timer_d    = '0;
               edge_cnt_d = '0;
               edge_ovf_d = 1'b0;
               state_d    = StSettle;
            end
         end
         StSettle: begin
            if (timer_q == SETTLE_LAST) begin
               timer_d = '0;
               state_d = StGate;
            end
         end
         StGate: begin
            if (ro_rise) begin
               if (edge_cnt_q == {CNT_W{1'b1}}) begin
                  edge_ovf_d = 1'b1;
               end else begin
                  edge_cnt_d = edge_cnt_q + 1'b1;
               end
            end
            // Results load on the way into DONE so they appear alongside the
            // done pulse and include an edge seen on the final gate cycle.
            if (timer_q == GATE_LAST) begin
               timer_d    = '0;
               state_d    = StDone;
               count_d    = edge_cnt_d;
               overflow_d = edge_ovf_d;
               done_d     = 1'b1;
            end
         end
         StDone: begin
            timer_d = timer_q;
            state_d = StIdle;
         end
         default: begin
            timer_d = '0;
            state_d = StIdle;
         end
      endcase

      // Outputs are registered from the next state, so they line up with the
      // state they describe without any combinational path to the pins.
      busy_d  = (state_d != StIdle);
      ro_en_d = ((state_d == StSettle) || (state_d == StGate)) ? {1'b1, sel_d} : 3'b000;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         timer_q    <= '0;
         sel_q      <= 2'b00;
         edge_cnt_q <= '0;
         edge_ovf_q <= 1'b0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         ro_en_q    <= 3'b000;
         ro_meta_q  <= 1'b0;
         ro_sync_q  <= 1'b0;
         ro_dly_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         sel_q      <= sel_d;
         edge_cnt_q <= edge_cnt_d;
         edge_ovf_q <= edge_ovf_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
         ro_en_q    <= ro_en_d;
         ro_meta_q  <= ro_meta_d;
         ro_sync_q  <= ro_sync_d;
         ro_dly_q   <= ro_dly_d;
      end
   end

   assign ro_en    = ro_en_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign count    = count_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_ro_freq_counter.sv
// Bench for ro_freq_counter with GATE_CYCLES=16, SETTLE_CYCLES=4, CNT_W=3.
// CNT_W=3 lets a clk/2 input saturate while the clk/4 case (4 edges) still fits.
// Expected results are queued when a start is accepted and checked on done.
module tb_ro_freq_counter;

   localparam int unsigned GATE   = 16;
   localparam int unsigned SETTLE = 4;
   localparam int unsigned CW     = 3;
   localparam int          LAT    = SETTLE + GATE + 1;

   logic          clk;
   logic          rst_n;
   logic          ro_in;
   logic          start;
   logic [1:0]    stage_sel;
   logic [2:0]    ro_en;
   logic          busy;
   logic          done;
   logic [CW-1:0] count;
   logic          overflow;

   ro_freq_counter #(
      .GATE_CYCLES  (GATE),
      .SETTLE_CYCLES(SETTLE),
      .CNT_W        (CW)
   ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ro_in    (ro_in),
      .start    (start),
      .stage_sel(stage_sel),
      .ro_en    (ro_en),
      .busy     (busy),
      .done     (done),
      .count    (count),
      .overflow (overflow)
   );

   typedef struct {
      int cyc;
      int cnt;
      int ovf;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests  = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   free_cyc = 0;
   int   done_seen = 0;
   int   ro_mode  = 0;   // 0: constant 0, 1: clk/4, 2: clk/2
   int   ro_ph    = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Oscillator model, changing away from the sampling edge.
   always @(negedge clk) begin
      ro_ph = ro_ph + 1;
      case (ro_mode)
         1:       ro_in = ro_ph[1];
         2:       ro_in = ro_ph[0];
         default: ro_in = 1'b0;
      endcase
   end

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_tests = n_tests + 1;
      if (obs !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Scoreboard consumer: every done pulse must match the oldest expectation.
   always begin
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      if (done === 1'b1) begin
         done_seen = done_seen + 1;
         if (sb_q.size() == 0) begin
            check_eq("spurious_done", 1, 0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check_eq("done_cycle", cyc, e.cyc);
            check_eq("count", int'(count), e.cnt);
            check_eq("overflow", int'(overflow), e.ovf);
         end
      end
   end

   // Called at a negedge with start=1 driven; models acceptance only in idle.
   task automatic offer_start();
      exp_t e;
      int   raw;
      int   maxv;
      if (cyc >= free_cyc) begin
         raw   = (ro_mode == 1) ? GATE / 4 : (ro_mode == 2) ? GATE / 2 : 0;
         maxv  = (1 << CW) - 1;
         e.cyc = cyc + LAT;
         e.cnt = (raw > maxv) ? maxv : raw;
         e.ovf = (raw > maxv) ? 1 : 0;
         sb_q.push_back(e);
         free_cyc = cyc + LAT + 1;
      end
   endtask

   // One full measurement, checking ro_en/busy every cycle. If chg_sel is set,
   // stage_sel is moved to 11 in the middle of the gate window.
   task automatic run_meas(input int mode, input logic [1:0] sel, input bit chg_sel);
      logic [2:0] en_exp;
      en_exp = {1'b1, sel};
      @(negedge clk);
      ro_mode   = mode;
      stage_sel = sel;
      start     = 1'b1;
      offer_start();
      @(negedge clk);
      start = 1'b0;
      for (int i = 1; i <= SETTLE + GATE; i++) begin
         if (i > 1) @(negedge clk);
         if (chg_sel && i == 10) stage_sel = 2'b11;
         check_eq("ro_en_run", int'(ro_en), int'(en_exp));
         check_eq("busy_run", int'(busy), 1);
         check_eq("done_early", int'(done), 0);
      end
      @(negedge clk);
      check_eq("ro_en_done", int'(ro_en), 0);
      check_eq("busy_done", int'(busy), 1);
      check_eq("done_pulse", int'(done), 1);
      @(negedge clk);
      check_eq("ro_en_after", int'(ro_en), 0);
      check_eq("busy_after", int'(busy), 0);
      check_eq("done_after", int'(done), 0);
      stage_sel = 2'b00;
   endtask

   initial begin
      int base;
      rst_n     = 1'b0;
      start     = 1'b0;
      stage_sel = 2'b00;
      ro_in     = 1'b0;
      #2;
      check_eq("rst_ro_en", int'(ro_en), 0);
      check_eq("rst_busy", int'(busy), 0);
      check_eq("rst_done", int'(done), 0);
      check_eq("rst_count", int'(count), 0);
      check_eq("rst_overflow", int'(overflow), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      free_cyc = cyc;
      repeat (2) @(negedge clk);

      run_meas(1, 2'b10, 1'b0);   // clk/4, 3 stages: count 4
      run_meas(0, 2'b00, 1'b0);   // no edges: count 0
      run_meas(2, 2'b01, 1'b0);   // clk/2 saturates at 7
      run_meas(0, 2'b11, 1'b0);   // overflow clears on the next window
      run_meas(1, 2'b01, 1'b1);   // stage_sel change mid-gate ignored
      check_eq("count_hold", int'(count), 4);

      // Start held high for 40 cycles: only two starts are accepted.
      base    = done_seen;
      ro_mode = 1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         start = 1'b1;
         offer_start();
      end
      @(negedge clk);
      start = 1'b0;
      repeat (30) @(negedge clk);
      check_eq("busy_repeat_dones", done_seen - base, 2);

      // Reset on the tenth gate cycle aborts the measurement.
      base = done_seen;
      @(negedge clk);
      start     = 1'b1;
      stage_sel = 2'b10;
      @(negedge clk);
      start = 1'b0;
      repeat (SETTLE + 9) @(negedge clk);
      check_eq("pre_rst_ro_en", int'(ro_en), 6);
      rst_n = 1'b0;
      #1;
      check_eq("abort_ro_en", int'(ro_en), 0);
      check_eq("abort_busy", int'(busy), 0);
      check_eq("abort_done", int'(done), 0);
      check_eq("abort_count", int'(count), 0);
      @(negedge clk);
      rst_n    = 1'b1;
      free_cyc = cyc;
      repeat (30) @(negedge clk);
      check_eq("abort_no_done", done_seen - base, 0);
      check_eq("abort_count_hold", int'(count), 0);
      check_eq("sb_empty", sb_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
